// File: rtl/altcpu_pkg.sv
// Shared types for the altCpu program sequencer: the issued record,
// the sequencer state encoding and the default end-of-program opcode.
package altcpu_pkg;

   typedef struct packed {
      logic       mode;
      logic [7:0] instr;
      logic [7:0] a;
      logic [7:0] b;
   } rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;

endpackage

// File: rtl/altcpu_program_sequencer_if.sv
// Valid/ready record stream from the sequencer towards the altCpu datapath.
interface altcpu_program_sequencer_if;

   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic [7:0] out_instr;
   logic       out_mode;

   modport master (
      output out_valid, out_a, out_b, out_instr, out_mode,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_a, out_b, out_instr, out_mode,
      output out_ready
   );

endinterface

// File: rtl/altcpu_prog_ram.sv
// Program store: DEPTH records, one write port, one registered read port
// whose output register holds its value while re is low.
module altcpu_prog_ram
   import altcpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  rec_t          wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output rec_t          rdata
);

   rec_t mem_q [DEPTH];
   rec_t rdata_q;
   rec_t rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/altcpu_program_sequencer.sv
// Loadable, replayable record feeder for the altCpu datapath.
//   state   | meaning
//   ST_IDLE | loading allowed; start launches a run from slot 0
//   ST_RUN  | out_* holds slot[pc]; RAM read register holds slot[pc+1]
module altcpu_program_sequencer
   import altcpu_pkg::*;
#(
   parameter int         DEPTH   = 16,
   parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_en,
   input  logic [7:0]                 ld_a,
   input  logic [7:0]                 ld_b,
   input  logic [7:0]                 ld_instr,
   input  logic                       ld_mode,
   input  logic                       ld_clear,
   input  logic                       start,
   input  logic                       abort,
   altcpu_program_sequencer_if.master out_if,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     prog_len,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [LW-1:0] prog_len_q, prog_len_d;
   rec_t          out_rec_q, out_rec_d;
   logic          done_q, done_d;
   rec_t          slot0_q, slot0_d;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   rec_t          ram_wdata;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   rec_t          ram_rdata;

   rec_t          ld_rec;
   logic [LW-1:0] pc_next1;
   logic          full_w;
   logic          xfer;

   assign ld_rec.mode  = ld_mode;
   assign ld_rec.instr = ld_instr;
   assign ld_rec.a     = ld_a;
   assign ld_rec.b     = ld_b;

   assign pc_next1 = {1'b0, pc_q} + LW'(1);
   assign full_w   = (prog_len_q == LW'(DEPTH));
   assign xfer     = (state_q == ST_RUN) && out_if.out_ready;

   altcpu_prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      prog_len_d = prog_len_q;
      out_rec_d  = out_rec_q;
      done_d     = 1'b0;
      slot0_d    = slot0_q;
      ram_we     = 1'b0;
      ram_waddr  = prog_len_q[AW-1:0];
      ram_wdata  = ld_rec;
      ram_re     = 1'b0;
      ram_raddr  = pc_q + AW'(2);

      case (state_q)
         ST_IDLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (start) begin
               // Slot 0 is shadowed so the first record and its HALT check
               // are available on the start edge, while the RAM fetches slot 1.
               if ((prog_len_q == '0) || (slot0_q.instr == HALT_OP)) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = ST_RUN;
                  pc_d      = '0;
                  out_rec_d = slot0_q;
                  ram_re    = 1'b1;
                  ram_raddr = AW'(1);
               end
            end else if (ld_clear) begin
               prog_len_d = '0;
            end else if (ld_en && !full_w) begin
               ram_we     = 1'b1;
               prog_len_d = prog_len_q + LW'(1);
               if (prog_len_q == '0) begin
                  slot0_d = ld_rec;
               end
            end
         end

         ST_RUN: begin
            if (xfer) begin
               if ((pc_next1 == prog_len_q) || (ram_rdata.instr == HALT_OP)) begin
                  state_d = ST_IDLE;
                  done_d  = !abort;
               end else if (abort) begin
                  state_d = ST_IDLE;
               end else begin
                  pc_d      = pc_q + AW'(1);
                  out_rec_d = ram_rdata;
                  ram_re    = 1'b1;
                  ram_raddr = pc_q + AW'(2);
               end
            end else if (abort) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         prog_len_q <= '0;
         out_rec_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         prog_len_q <= prog_len_d;
         out_rec_q  <= out_rec_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      slot0_q <= slot0_d;
   end

   assign out_if.out_valid = (state_q == ST_RUN);
   assign out_if.out_mode  = out_rec_q.mode;
   assign out_if.out_instr = out_rec_q.instr;
   assign out_if.out_a     = out_rec_q.a;
   assign out_if.out_b     = out_rec_q.b;

   assign busy     = (state_q == ST_RUN);
   assign done     = done_q;
   assign prog_len = prog_len_q;
   assign full     = full_w;

endmodule

// File: tb/tb_altcpu_program_sequencer.sv
// Bench for altcpu_program_sequencer: directed scenarios plus randomized
// programs, checked against a queue model of the loaded program.
module tb_altcpu_program_sequencer;
   import altcpu_pkg::*;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_en, ld_mode, ld_clear, start, abort;
   logic [7:0]    ld_a, ld_b, ld_instr;
   logic          busy, done, full;
   logic [LW-1:0] prog_len;

   altcpu_program_sequencer_if bus();

   altcpu_program_sequencer #(.DEPTH(DEPTH), .HALT_OP(8'hFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .ld_en    (ld_en),
      .ld_a     (ld_a),
      .ld_b     (ld_b),
      .ld_instr (ld_instr),
      .ld_mode  (ld_mode),
      .ld_clear (ld_clear),
      .start    (start),
      .abort    (abort),
      .out_if   (bus),
      .busy     (busy),
      .done     (done),
      .prog_len (prog_len),
      .full     (full)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   rec_t model_prog[$];
   rec_t exp_q[$];
   rec_t got_q[$];
   int   done_cnt, done_lat, stab_err, timeout, first_cyc, last_cyc, post_done;

   function automatic rec_t mk(input logic m, input logic [7:0] i, input logic [7:0] a,
                               input logic [7:0] b);
      rec_t r;
      r.mode = m; r.instr = i; r.a = a; r.b = b;
      return r;
   endfunction

   function automatic rec_t cur_out();
      rec_t r;
      r.mode = bus.out_mode; r.instr = bus.out_instr; r.a = bus.out_a; r.b = bus.out_b;
      return r;
   endfunction

   // Records a run will issue: everything up to (not including) the first HALT.
   function automatic void build_exp();
      exp_q.delete();
      for (int i = 0; i < model_prog.size(); i++) begin
         if (model_prog[i].instr == 8'hFF) break;
         exp_q.push_back(model_prog[i]);
      end
   endfunction

   function automatic rec_t rand_rec(input int halt_pct);
      rec_t r;
      r.mode  = 1'($urandom_range(0, 1));
      r.instr = (int'($urandom_range(0, 99)) < halt_pct) ? 8'hFF : 8'($urandom_range(0, 254));
      r.a     = 8'($urandom);
      r.b     = 8'($urandom);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rec(input rec_t r);
      ld_mode = r.mode; ld_instr = r.instr; ld_a = r.a; ld_b = r.b;
      ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
      if (model_prog.size() < DEPTH) model_prog.push_back(r);
   endtask

   task automatic clear_prog();
      ld_clear = 1'b1;
      tick();
      ld_clear = 1'b0;
      model_prog.delete();
   endtask

   // Drives one run and records what was accepted; rmode 0=ready high,
   // 1=toggle, 2=random. abort_at>=0 aborts once that many transfers happened.
   task automatic run(input int rmode, input int abort_at, input bit noise);
      rec_t held, cur;
      bit   stalled = 1'b0, aborted = 1'b0, r, tog = 1'b1;
      got_q.delete();
      done_cnt = 0; done_lat = -99; stab_err = 0; timeout = 1;
      first_cyc = -1; last_cyc = -1; post_done = 0;
      held = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 4 * DEPTH + 40; cyc++) begin
         if (done) begin
            done_cnt++;
            done_lat = cyc - last_cyc;
         end
         if (!bus.out_valid) begin
            timeout = 0;
            break;
         end
         cur = cur_out();
         if (stalled && cur !== held) stab_err++;
         case (rmode)
            0:       r = 1'b1;
            1:       begin r = tog; tog = ~tog; end
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (!aborted && abort_at >= 0 && got_q.size() == abort_at) begin
            abort = 1'b1; aborted = 1'b1; r = 1'b0;
         end
         bus.out_ready = r;
         if (noise) begin
            ld_en = 1'($urandom_range(0, 1)); ld_a = 8'($urandom); ld_instr = 8'h00;
            ld_clear = 1'($urandom_range(0, 1));
         end
         if (r) begin
            got_q.push_back(cur);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         stalled = !r;
         held = cur;
         tick();
         abort = 1'b0;
      end
      ld_en = 1'b0; ld_clear = 1'b0; bus.out_ready = 1'b0;
      tick();
      if (done) post_done++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got valid=%b busy=%b done=%b exp 0 0 0", bus.out_valid, busy, done);
      end
      checks++;
      if (prog_len !== '0 || full !== 1'b0) begin
         errors++;
         $display("FAIL reset_len got len=%0d full=%b exp 0 0", prog_len, full);
      end
      checks++;
      if (cur_out() !== '0) begin
         errors++;
         $display("FAIL reset_out got %h exp 0", cur_out());
      end
   endtask

   task automatic test_basic();
      load_rec(mk(1'b0, 8'h28, 8'h0F, 8'h03));
      load_rec(mk(1'b1, 8'h10, 8'h05, 8'h02));
      load_rec(mk(1'b0, 8'h28, 8'hFF, 8'h01));
      run(0, -1, 1'b0);
      build_exp();
      checks++;
      if (got_q.size() != 3) begin
         errors++; $display("FAIL basic_count got %0d exp 3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL basic_rec%0d got %h exp %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (first_cyc != 0 || last_cyc != 2) begin
         errors++; $display("FAIL basic_timing got first=%0d last=%0d exp 0 2", first_cyc, last_cyc);
      end
      checks++;
      if (done_cnt != 1 || done_lat != 1 || post_done != 0 || timeout != 0) begin
         errors++;
         $display("FAIL basic_done got cnt=%0d lat=%0d post=%0d to=%0d exp 1 1 0 0",
                  done_cnt, done_lat, post_done, timeout);
      end
      checks++;
      if (prog_len !== LW'(3)) begin
         errors++; $display("FAIL basic_len got %0d exp 3", prog_len);
      end
   endtask

   task automatic test_stall();
      run(1, -1, 1'b1);
      build_exp();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL stall_rec%0d got %h exp %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (stab_err != 0 || done_cnt != 1 || done_lat != 1) begin
         errors++;
         $display("FAIL stall_hold got stab=%0d done=%0d lat=%0d exp 0 1 1", stab_err, done_cnt, done_lat);
      end
      checks++;
      if (prog_len !== LW'(model_prog.size())) begin
         errors++; $display("FAIL stall_len got %0d exp %0d", prog_len, model_prog.size());
      end
   endtask

   task automatic test_halt();
      clear_prog();
      load_rec(mk(1'b0, 8'h28, 8'h0F, 8'h03));
      load_rec(mk(1'b0, 8'hFF, 8'h00, 8'h00));
      load_rec(mk(1'b0, 8'h10, 8'h01, 8'h01));
      run(0, -1, 1'b0);
      checks++;
      if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== model_prog[0])) begin
         errors++; $display("FAIL halt_mid got n=%0d exp 1 record %h", got_q.size(), model_prog[0]);
      end
      checks++;
      if (done_cnt != 1 || done_lat != 1) begin
         errors++; $display("FAIL halt_done got cnt=%0d lat=%0d exp 1 1", done_cnt, done_lat);
      end
      clear_prog();
      load_rec(mk(1'b1, 8'hFF, 8'h11, 8'h22));
      load_rec(mk(1'b0, 8'h28, 8'h33, 8'h44));
      run(0, -1, 1'b0);
      checks++;
      if (got_q.size() != 0 || done_cnt != 1 || done_lat != 1) begin
         errors++;
         $display("FAIL halt_slot0 got n=%0d done=%0d lat=%0d exp 0 1 1", got_q.size(), done_cnt, done_lat);
      end
   endtask

   task automatic test_full();
      clear_prog();
      for (int i = 0; i < DEPTH; i++) load_rec(rand_rec(0));
      load_rec(mk(1'b1, 8'h5A, 8'hEE, 8'hDD));
      checks++;
      if (full !== 1'b1 || prog_len !== LW'(DEPTH)) begin
         errors++; $display("FAIL full_flag got full=%b len=%0d exp 1 %0d", full, prog_len, DEPTH);
      end
      run(2, -1, 1'b0);
      build_exp();
      checks++;
      if (got_q.size() != DEPTH) begin
         errors++; $display("FAIL full_count got %0d exp %0d", got_q.size(), DEPTH);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL full_rec%0d got %h exp %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || stab_err != 0) begin
         errors++; $display("FAIL full_done got done=%0d stab=%0d exp 1 0", done_cnt, stab_err);
      end
   endtask

   task automatic test_abort();
      clear_prog();
      for (int i = 0; i < 5; i++) load_rec(rand_rec(0));
      run(0, 2, 1'b0);
      checks++;
      if (got_q.size() != 2 || timeout != 0) begin
         errors++; $display("FAIL abort_count got n=%0d to=%0d exp 2 0", got_q.size(), timeout);
      end
      checks++;
      if (done_cnt != 0 || post_done != 0) begin
         errors++; $display("FAIL abort_nodone got %0d exp 0", done_cnt + post_done);
      end
      run(0, -1, 1'b0);
      build_exp();
      checks++;
      if (got_q.size() != 5) begin
         errors++; $display("FAIL replay_count got %0d exp 5", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL replay_rec%0d got %h exp %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      model_prog.delete();
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cur_out() !== '0) begin
         errors++;
         $display("FAIL rstmid_out got valid=%b busy=%b done=%b out=%h exp 0 0 0 0",
                  bus.out_valid, busy, done, cur_out());
      end
      checks++;
      if (prog_len !== '0 || full !== 1'b0) begin
         errors++; $display("FAIL rstmid_len got %0d exp 0", prog_len);
      end
      run(0, -1, 1'b0);
      checks++;
      if (got_q.size() != 0 || done_cnt != 1 || done_lat != 1) begin
         errors++;
         $display("FAIL rstmid_empty got n=%0d done=%0d lat=%0d exp 0 1 1", got_q.size(), done_cnt, done_lat);
      end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 25; it++) begin
         clear_prog();
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) load_rec(rand_rec(15));
         run(2, -1, 1'b1);
         build_exp();
         checks++;
         if (got_q.size() != exp_q.size() || timeout != 0) begin
            errors++;
            $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rand%0d_rec%0d got %h exp %h", it, i, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (done_cnt != 1 || done_lat != 1 || stab_err != 0 || post_done != 0) begin
            errors++;
            $display("FAIL rand%0d_done got cnt=%0d lat=%0d stab=%0d post=%0d exp 1 1 0 0",
                     it, done_cnt, done_lat, stab_err, post_done);
         end
         checks++;
         if (prog_len !== LW'(model_prog.size())) begin
            errors++; $display("FAIL rand%0d_len got %0d exp %0d", it, prog_len, model_prog.size());
         end
      end
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_mode = 1'b0; ld_clear = 1'b0; start = 1'b0; abort = 1'b0;
      ld_a = '0; ld_b = '0; ld_instr = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_halt();
      test_full();
      test_abort();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/altcpu_program_sequencer.md
# altcpu_program_sequencer

Upstream feeder for the altCpu datapath. Holds a small program of operand/instruction records and issues them one per handshake. Each record is {mode, instr, a, b}, the exact inputs altCpu consumes. It replaces hard-wired stimulus with a loadable, replayable instruction stream driven by one clock.

## Interface
- DEPTH, 16: program slots; power of two, 2..256
- HALT_OP, 8'hFF: instruction value that ends a run; the HALT record itself is not issued
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ld_en  in  1  write one record at load pointer; honoured only in IDLE
- ld_a  in  8  operand a for load
- ld_b  in  8  operand b for load
- ld_instr  in  8  instruction (opcode/operand byte) for load
- ld_mode  in  1  mode bit for load
- ld_clear  in  1  reset load pointer/length to 0; IDLE only; wins over ld_en
- start  in  1  begin run from slot 0; IDLE only
- abort  in  1  end run immediately, return to IDLE
- out_valid  out  1  record on out_* is valid
- out_ready  in  1  downstream accepts record
- out_a  out  8  to altCpu a
- out_b  out  8  to altCpu b
- out_instr  out  8  to altCpu instr
- out_mode  out  1  to altCpu mode
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- prog_len  out  $clog2(DEPTH)+1  records loaded
- full  out  1  prog_len == DEPTH

## Operation
- States: IDLE, RUN.
- IDLE:
  - ld_en with !full writes slot[prog_len] and increments prog_len.
  - ld_en while full is ignored; no wrap, no overwrite.
  - start with prog_len==0: no RUN; done pulses next cycle.
  - start with prog_len>0: pc←0, go to RUN.
- RUN:
  - out_* are driven from registers holding slot[pc].
  - Transfer occurs when out_valid && out_ready.
  - On transfer: pc+1 == prog_len, or slot[pc+1].instr == HALT_OP → IDLE, done=1. Otherwise pc←pc+1 and the next record is presented on the following cycle.
  - A HALT_OP record at slot 0 ends the run at start: nothing is issued and done pulses.
  - ld_en, ld_clear and start are ignored in RUN.
  - abort: IDLE next cycle, out_valid=0, no done pulse.
- Stability: while out_valid && !out_ready, out_* are held constant.
- Program contents and prog_len survive runs, so a program can be replayed by reissuing start.
- Reset values: state IDLE, pc=0, prog_len=0, out_valid=0, out_a/out_b/out_instr=8'h00, out_mode=0, busy=0, done=0, full=0. Memory contents are not reset.
- Reset mid-run: the run ends with no done pulse, and the program is discarded (prog_len=0).

## Timing
- Load: slot is written on the ld_en edge. prog_len/full update the same edge, visible next cycle.
- start→first out_valid: 1 cycle (registered read of slot 0).
- Steady state with out_ready held high: one record per cycle, no bubbles. The lookahead read of slot[pc+1] is registered.
- done asserts the cycle after the final transfer, together with busy=0.
- Simultaneous start and abort in IDLE: abort wins, so the block stays in IDLE.
- Simultaneous transfer and abort: the transfer counts; state goes to IDLE with no done.

## Structure
- Shared package `altcpu_pkg`:
  - record typedef {mode, instr[7:0], a[7:0], b[7:0]} (25 bits)
  - state enum
  - default HALT_OP constant
- Sub-module `altcpu_prog_ram`: DEPTH×25 synchronous RAM, one write port, one registered read port.
- Top: FSM, pc, load pointer, output register.

## Test plan
- Reset, then load 3 records {0,28,0F,03}, {1,10,05,02}, {0,28,FF,01}, start, out_ready=1 → three consecutive transfers in order; done 1 cycle after the third; prog_len=3 retained.
- Same program, out_ready toggling 1/0 each cycle → out_* stable while stalled; exactly 3 transfers; no duplicates or drops.
- Load {0,28,0F,03}, {0,FF,00,00}, {0,10,01,01}, start → only the first record issues; done pulses; third never appears.
- Load DEPTH records, then one more ld_en → full=1, prog_len=DEPTH, extra write ignored; run issues DEPTH records with last = slot DEPTH-1.
- abort after 2nd transfer of a 5-record run → out_valid=0 next cycle, no done; restart replays from slot 0.
- rst asserted mid-run → all outputs at reset values next cycle; prog_len=0; start then gives an immediate done with no transfers.
